// File: rtl/rgb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pkg
//  Purpose  : Shared colour codes, per-channel fade state type and a colour
//             legality helper for the RGB fade driver.
//  Revision : 1.0  initial release
// ============================================================================
package rgb_pkg;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_RESET = 3'b001;

    typedef enum logic [0:0] {
        HOLD = 1'b0,
        FADE = 1'b1
    } ch_state_t;

    // 000 and 111 never come from the sequencer; they mark a broken bus.
    function automatic logic is_illegal(input logic [2:0] col);
        return (col == COL_BLACK) || (col == COL_WHITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_fade_channel.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_channel
//  Purpose  : One LED channel: linear duty fade toward a full-on/full-off
//             target, stepped once per PWM period, and PWM comparison.
//             Build option GAMMA_EN: square-law compare value (registered).
//  Revision : 1.0  initial release
// ============================================================================
module rgb_fade_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrap,
    input  logic                tgt_on,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                enable,
    output logic                led,
    output logic                fading
);

    // One extra bit so step arithmetic never wraps around.
    localparam logic [PWM_BITS:0] c_MAX  = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0] c_STEP = FADE_STEP[PWM_BITS:0];

    ch_state_t             r_state;
    ch_state_t             w_state_next;
    logic [PWM_BITS-1:0]   r_duty;
    logic [PWM_BITS-1:0]   w_duty_next;
    logic [PWM_BITS:0]     w_duty_w;
    logic [PWM_BITS:0]     w_target;
    logic [PWM_BITS:0]     w_sum;
    logic [PWM_BITS:0]     w_stepped;
    logic [PWM_BITS-1:0]   w_cmp;
    logic                  r_led;

    assign w_duty_w = {1'b0, r_duty};
    assign w_target = tgt_on ? c_MAX : '0;

    // Candidate duty after one saturating step toward the target.
    always_comb begin
        w_sum     = w_duty_w + c_STEP;
        w_stepped = w_duty_w;
        if (w_duty_w < w_target) begin
            w_stepped = (w_sum >= w_target) ? w_target : w_sum;
        end else if (w_duty_w > w_target) begin
            w_stepped = (w_duty_w >= (w_target + c_STEP)) ? (w_duty_w - c_STEP) : w_target;
        end
    end

    // State and duty registers; duty only moves at the period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HOLD;
            r_duty  <= '0;
        end else begin
            r_state <= w_state_next;
            r_duty  <= w_duty_next;
        end
    end

    // Next-state / next-duty: leave FADE on the wrap that lands on target,
    // or immediately if the target swung back to the current duty.
    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        if (wrap) begin
            w_duty_next = w_stepped[PWM_BITS-1:0];
        end
        case (r_state)
            HOLD: begin
                if ((w_duty_w != w_target) && !(wrap && (w_stepped == w_target))) begin
                    w_state_next = FADE;
                end
            end
            FADE: begin
                if (w_duty_w == w_target) begin
                    w_state_next = HOLD;
                end else if (wrap && (w_stepped == w_target)) begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = HOLD;
        endcase
    end

`ifdef GAMMA_EN
    logic [2*PWM_BITS-1:0] w_sq;
    logic [PWM_BITS-1:0]   r_cmp;

    assign w_sq = r_duty * r_duty;

    // Registered square-law compare value for perceptual brightness.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp <= '0;
        end else begin
            r_cmp <= w_sq[2*PWM_BITS-1:PWM_BITS];
        end
    end

    assign w_cmp = r_cmp;
`else
    assign w_cmp = r_duty;
`endif

    // PWM output, gated by enable; registered for clean pin timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= enable & (cnt < w_cmp);
        end
    end

    assign led    = r_led;
    assign fading = (r_state == FADE);

endmodule
`default_nettype wire

// File: rtl/rgb_fade_driver.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_driver
//  Purpose  : Decodes the 3-bit colour bus into three fading PWM LED
//             channels, flags illegal codes and reports fade activity.
//             Build option GAMMA_EN: square-law brightness in each channel.
//  Revision : 1.0  initial release
// ============================================================================
module rgb_fade_driver
    import rgb_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] colour,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       illegal,
    output logic       busy
);

    localparam logic [PWM_BITS-1:0] c_CNT_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] r_cnt;
    logic                w_wrap;
    logic [2:0]          r_target;
    logic                r_illegal;
    logic                r_busy;
    logic [2:0]          w_fading;
    logic [2:0]          w_led;

    assign w_wrap = (r_cnt == c_CNT_MAX);

    // Free-running PWM period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Latch legal colours as targets; illegal codes keep the last target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target  <= COL_RESET;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= is_illegal(colour);
            if (!is_illegal(colour)) begin
                r_target <= colour;
            end
        end
    end

    // Any channel still fading makes the block busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_fading;
        end
    end

    // Channel 2 = red, 1 = green, 0 = blue, matching the colour bit order.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            rgb_fade_channel #(
                .PWM_BITS  (PWM_BITS),
                .FADE_STEP (FADE_STEP)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .wrap   (w_wrap),
                .tgt_on (r_target[gi]),
                .cnt    (r_cnt),
                .enable (enable),
                .led    (w_led[gi]),
                .fading (w_fading[gi])
            );
        end
    endgenerate

    assign led_r   = w_led[2];
    assign led_g   = w_led[1];
    assign led_b   = w_led[0];
    assign illegal = r_illegal;
    assign busy    = r_busy;

endmodule
`default_nettype wire
